tmds_encoder_hdmi: RTL and testbench

//  One-lane TMDS/TERC4 encoder for HDMI, the successor of our DVI-only encoder.

---
 rtl/hdmi_pkg.sv | 54 +++++
 rtl/tmds_qm_stage.sv | 29 ++
 rtl/tmds_encoder_hdmi.sv | 128 ++++++++++++
 tb/tb_tmds_encoder_hdmi.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_pkg.sv
// Shared HDMI lane constants and stage bundles.
// Code tables are indexed by the symbol value.
package hdmi_pkg;

  localparam int TMDS_W = 10;

  typedef enum logic [1:0] {
    MODE_CTRL  = 2'b00,
    MODE_VIDEO = 2'b01,
    MODE_TERC4 = 2'b10,
    MODE_GUARD = 2'b11
  } mode_e;

  localparam logic [TMDS_W-1:0] CTRL_CODE [4] = '{
    10'b1101010100, 10'b0010101011,
    10'b0101010100, 10'b1010101011
  };

  localparam logic [TMDS_W-1:0] TERC4_CODE [16] = '{
    10'b1010011100, 10'b1001100011,
    10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110,
    10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001,
    10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001,
    10'b0101100011, 10'b1011000011
  };

  localparam logic [TMDS_W-1:0] VGUARD_CODE [3] = '{
    10'b1011001100, 10'b0100110011,
    10'b1011001100
  };

  localparam logic [TMDS_W-1:0] DGUARD = 10'b0100110011;

  // bal is signed two's complement, -4..+4
  typedef struct packed {
    mode_e      mode;
    logic [1:0] ctrl;
    logic [3:0] aux;
    logic       gsel;
    logic [8:0] qm;
    logic [3:0] bal;
  } s1_t;

  function automatic logic [3:0] n1(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c + {3'b000, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/tmds_qm_stage.sv
// Transition-minimised q_m word plus
// its ones-balance relative to four.
module tmds_qm_stage
  import hdmi_pkg::*;
(
  input  logic [7:0] data,
  output logic [8:0] qm,
  output logic [3:0] balance
);

  logic       use_xnor;
  logic [8:0] q;

  // Chain XOR/XNOR through the byte, then count ones
  always_comb begin
    use_xnor = (n1(data) > 4'd4) ||
               ((n1(data) == 4'd4) && !data[0]);
    q    = '0;
    q[0] = data[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = use_xnor ? ~(q[i-1] ^ data[i])
                      :  (q[i-1] ^ data[i]);
    end
    q[8]    = ~use_xnor;
    qm      = q;
    balance = n1(q[7:0]) - 4'd4;
  end

endmodule

// File: rtl/tmds_encoder_hdmi.sv
// One HDMI lane: TMDS video, control,
// TERC4 and guard-band characters.
module tmds_encoder_hdmi
  import hdmi_pkg::*;
#(
  parameter int CHANNEL = 0,
  parameter int PIPE    = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_ce,
  input  logic [1:0]        i_mode,
  input  logic [7:0]        i_data,
  input  logic [1:0]        i_ctrl,
  input  logic [3:0]        i_aux,
  input  logic              i_gsel,
  output logic [TMDS_W-1:0] o_tmds,
  output logic signed [4:0] o_bias
);

  localparam logic [TMDS_W-1:0] VG =
    VGUARD_CODE[CHANNEL];

  logic [8:0]        qm;
  logic [3:0]        bal4;
  s1_t               s1_in;
  s1_t               s1;
  logic [TMDS_W-1:0] tmds_nx;
  logic signed [4:0] bias_nx;
  logic signed [4:0] bal;
  logic              q8;
  logic [7:0]        q;
  logic              zero;
  logic              same;

  tmds_qm_stage u_qm (
    .data    (i_data),
    .qm      (qm),
    .balance (bal4)
  );

  // Bundle the first-stage results
  always_comb begin
    s1_in = '{
      mode: mode_e'(i_mode),
      ctrl: i_ctrl,
      aux:  i_aux,
      gsel: i_gsel,
      qm:   qm,
      bal:  bal4
    };
  end

  generate
    if (PIPE == 2) begin : g_p2
      s1_t s1_q;
      // Stage-1 register, cleared to a ctrl-00 character
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          s1_q <= '0;
        end else if (i_ce) begin
          s1_q <= s1_in;
        end
      end
      assign s1 = s1_q;
    end else if (PIPE == 1) begin : g_p1
      assign s1 = s1_in;
    end else begin : g_bad
      $error("tmds_encoder_hdmi: PIPE must be 1 or 2");
    end
  endgenerate

  // DC-balance decision and character select
  always_comb begin
    q       = s1.qm[7:0];
    q8      = s1.qm[8];
    bal     = $signed({s1.bal, 1'b0});
    zero    = (o_bias == 5'sd0) || (bal == 5'sd0);
    same    = !zero && (o_bias[4] == bal[4]);
    tmds_nx = CTRL_CODE[0];
    bias_nx = '0;
    unique case (s1.mode)
      MODE_VIDEO: begin
        unique case (1'b1)
          zero: begin
            tmds_nx = {~q8, q8, q8 ? q : ~q};
            bias_nx = q8 ? o_bias + bal
                         : o_bias - bal;
          end
          same: begin
            tmds_nx = {1'b1, q8, ~q};
            bias_nx = o_bias
                    + $signed({3'b000, q8, 1'b0})
                    - bal;
          end
          default: begin
            tmds_nx = {1'b0, q8, q};
            bias_nx = o_bias + bal
                    - $signed({3'b000, ~q8, 1'b0});
          end
        endcase
      end
      MODE_CTRL: tmds_nx = CTRL_CODE[s1.ctrl];
      MODE_TERC4: tmds_nx = TERC4_CODE[s1.aux];
      MODE_GUARD: begin
        if (!s1.gsel) begin
          tmds_nx = VG;
        end else if (CHANNEL == 0) begin
          tmds_nx = TERC4_CODE[{2'b11, s1.ctrl}];
        end else begin
          tmds_nx = DGUARD;
        end
      end
    endcase
  end

  // Output character and running disparity
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_tmds <= CTRL_CODE[0];
      o_bias <= '0;
    end else if (i_ce) begin
      o_tmds <= tmds_nx;
      o_bias <= bias_nx;
    end
  end

endmodule

// File: tb/tb_tmds_encoder_hdmi.sv
// Bench for tmds_encoder_hdmi: lanes 0/1 at
// PIPE=2, lane 2 at PIPE=1, shared stimulus.
module tb_tmds_encoder_hdmi;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_ce = 1'b0;
  logic [1:0] i_mode = '0;
  logic [7:0] i_data = '0;
  logic [1:0] i_ctrl = '0;
  logic [3:0] i_aux = '0;
  logic       i_gsel = 1'b0;

  logic [9:0]        t0, t1, t2;
  logic signed [4:0] b0, b1, b2;

  always #5 i_clk = ~i_clk;

  tmds_encoder_hdmi #(.CHANNEL(0), .PIPE(2)) u0 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ce(i_ce),
    .i_mode(i_mode), .i_data(i_data), .i_ctrl(i_ctrl),
    .i_aux(i_aux), .i_gsel(i_gsel),
    .o_tmds(t0), .o_bias(b0)
  );

  tmds_encoder_hdmi #(.CHANNEL(1), .PIPE(2)) u1 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ce(i_ce),
    .i_mode(i_mode), .i_data(i_data), .i_ctrl(i_ctrl),
    .i_aux(i_aux), .i_gsel(i_gsel),
    .o_tmds(t1), .o_bias(b1)
  );

  tmds_encoder_hdmi #(.CHANNEL(2), .PIPE(1)) u2 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ce(i_ce),
    .i_mode(i_mode), .i_data(i_data), .i_ctrl(i_ctrl),
    .i_aux(i_aux), .i_gsel(i_gsel),
    .o_tmds(t2), .o_bias(b2)
  );

  typedef struct {
    logic [9:0] c0;
    logic [9:0] c1;
    int         b;
  } e2_t;

  typedef struct {
    logic [9:0] c2;
    int         b;
  } e1_t;

  typedef struct {
    logic [1:0] m;
    logic [7:0] d;
    logic [1:0] c;
    logic [3:0] a;
    logic       g;
    logic [9:0] x0;
    logic [9:0] x1;
    logic [9:0] x2;
    int         xb;
  } vec_t;

  localparam logic [9:0] C0 = 10'b1101010100;
  localparam logic [9:0] DG = 10'b0100110011;
  localparam logic [9:0] VG = 10'b1011001100;

  logic [9:0] ct [4] = '{
    10'b1101010100, 10'b0010101011,
    10'b0101010100, 10'b1010101011
  };

  logic [9:0] t4 [16] = '{
    10'b1010011100, 10'b1001100011,
    10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110,
    10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001,
    10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001,
    10'b0101100011, 10'b1011000011
  };

  e2_t sb2[$];
  e1_t sb1[$];
  e2_t cur2;
  e1_t cur1;
  int  mb0, mb1, mb2;
  int  n_cmp = 0;
  int  n_bad = 0;

  function automatic logic [9:0] model(
    input logic [1:0] m, input logic [7:0] d,
    input logic [1:0] c, input logic [3:0] a,
    input logic g, input int ch, inout int bias);
    int         ones;
    int         n1q;
    int         n0q;
    bit         x;
    logic [8:0] qv;
    logic [9:0] r;
    r = C0;
    if (m == 2'b01) begin
      ones = 0;
      for (int i = 0; i < 8; i++) ones += d[i];
      x = (ones > 4) || (ones == 4 && d[0] == 1'b0);
      qv = '0;
      qv[0] = d[0];
      for (int i = 1; i < 8; i++)
        qv[i] = x ? ~(qv[i-1] ^ d[i]) : (qv[i-1] ^ d[i]);
      qv[8] = !x;
      n1q = 0;
      for (int i = 0; i < 8; i++) n1q += qv[i];
      n0q = 8 - n1q;
      if (bias == 0 || n1q == n0q) begin
        r = {~qv[8], qv[8], qv[8] ? qv[7:0] : ~qv[7:0]};
        bias += qv[8] ? (n1q - n0q) : (n0q - n1q);
      end else if ((bias > 0 && n1q > n0q) ||
                   (bias < 0 && n0q > n1q)) begin
        r = {1'b1, qv[8], ~qv[7:0]};
        bias += 2 * int'(qv[8]) + n0q - n1q;
      end else begin
        r = {1'b0, qv[8], qv[7:0]};
        bias += n1q - n0q - 2 * int'(!qv[8]);
      end
    end else begin
      bias = 0;
      if (m == 2'b00) r = ct[c];
      else if (m == 2'b10) r = t4[a];
      else if (!g) r = (ch == 1) ? DG : VG;
      else r = (ch == 0) ? t4[{2'b11, c}] : DG;
    end
    return r;
  endfunction

  function automatic vec_t mk(
    input logic [1:0] m, input logic [7:0] d,
    input logic [1:0] c, input logic [3:0] a,
    input logic g, input logic [9:0] x0,
    input logic [9:0] x1, input logic [9:0] x2,
    input int xb);
    vec_t v;
    v = '{m, d, c, a, g, x0, x1, x2, xb};
    return v;
  endfunction

  task automatic chk(input string nm, input int got,
                     input int want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic chk10(input string nm, input logic [9:0] got,
                       input logic [9:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", nm, got, want);
    end
  endtask

  task automatic check_out(input string nm);
    chk10({nm, " tmds ch0"}, t0, cur2.c0);
    chk10({nm, " tmds ch1"}, t1, cur2.c1);
    chk10({nm, " tmds ch2"}, t2, cur1.c2);
    chk({nm, " bias ch0"}, int'(b0), cur2.b);
    chk({nm, " bias ch1"}, int'(b1), cur2.b);
    chk({nm, " bias ch2"}, int'(b2), cur1.b);
    chk({nm, " bias range"},
        int'(b2 >= -5'sd10 && b2 <= 5'sd10), 1);
  endtask

  task automatic reset_model();
    sb2.delete();
    sb1.delete();
    sb2.push_back('{C0, C0, 0});
    cur2 = '{C0, C0, 0};
    cur1 = '{C0, 0};
    mb0 = 0;
    mb1 = 0;
    mb2 = 0;
  endtask

  task automatic apply(
    input logic ce, input logic [1:0] m,
    input logic [7:0] d, input logic [1:0] c,
    input logic [3:0] a, input logic g,
    input bit tab, input logic [9:0] x0,
    input logic [9:0] x1, input logic [9:0] x2,
    input int xb, input string nm);
    logic [9:0] r0, r1, r2;
    i_ce = ce;
    i_mode = m;
    i_data = d;
    i_ctrl = c;
    i_aux = a;
    i_gsel = g;
    if (ce) begin
      r0 = model(m, d, c, a, g, 0, mb0);
      r1 = model(m, d, c, a, g, 1, mb1);
      r2 = model(m, d, c, a, g, 2, mb2);
      if (tab) begin
        sb2.push_back('{x0, x1, xb});
        sb1.push_back('{x2, xb});
      end else begin
        sb2.push_back('{r0, r1, mb0});
        sb1.push_back('{r2, mb2});
      end
    end
    @(posedge i_clk);
    #1;
    if (ce) begin
      if (sb2.size() == 0 || sb1.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s: scoreboard empty", nm);
      end else begin
        cur2 = sb2.pop_front();
        cur1 = sb1.pop_front();
      end
    end
    check_out(nm);
    @(negedge i_clk);
  endtask

  initial begin
    vec_t tab[$];
    vec_t v;
    logic ce;
    logic [1:0] m;

    for (int i = 0; i < 4; i++)
      tab.push_back(mk(2'b00, 8'h00, 2'(i), 4'h0, 1'b0,
                       ct[i], ct[i], ct[i], 0));
    for (int i = 0; i < 16; i++)
      tab.push_back(mk(2'b10, 8'h00, 2'b00, 4'(i), 1'b0,
                       t4[i], t4[i], t4[i], 0));
    tab.push_back(mk(2'b11, 8'h00, 2'b00, 4'h0, 1'b0,
                     VG, DG, VG, 0));
    tab.push_back(mk(2'b11, 8'h00, 2'b10, 4'h0, 1'b1,
                     10'b0101100011, DG, DG, 0));
    tab.push_back(mk(2'b11, 8'h00, 2'b00, 4'h0, 1'b1,
                     10'b1010001110, DG, DG, 0));
    tab.push_back(mk(2'b01, 8'h00, 2'b00, 4'h0, 1'b0,
                     10'b0100000000, 10'b0100000000,
                     10'b0100000000, -8));
    tab.push_back(mk(2'b01, 8'h00, 2'b00, 4'h0, 1'b0,
                     10'b1111111111, 10'b1111111111,
                     10'b1111111111, 2));
    tab.push_back(mk(2'b01, 8'h00, 2'b00, 4'h0, 1'b0,
                     10'b0100000000, 10'b0100000000,
                     10'b0100000000, -6));
    tab.push_back(mk(2'b00, 8'h00, 2'b00, 4'h0, 1'b0,
                     C0, C0, C0, 0));
    tab.push_back(mk(2'b01, 8'h00, 2'b00, 4'h0, 1'b0,
                     10'b0100000000, 10'b0100000000,
                     10'b0100000000, -8));
    tab.push_back(mk(2'b00, 8'h00, 2'b01, 4'h0, 1'b0,
                     ct[1], ct[1], ct[1], 0));
    tab.push_back(mk(2'b01, 8'h00, 2'b00, 4'h0, 1'b0,
                     10'b0100000000, 10'b0100000000,
                     10'b0100000000, -8));
    tab.push_back(mk(2'b00, 8'h00, 2'b00, 4'h0, 1'b0,
                     C0, C0, C0, 0));
    tab.push_back(mk(2'b01, 8'hFF, 2'b00, 4'h0, 1'b0,
                     10'b1000000000, 10'b1000000000,
                     10'b1000000000, -8));
    tab.push_back(mk(2'b00, 8'h00, 2'b00, 4'h0, 1'b0,
                     C0, C0, C0, 0));
    tab.push_back(mk(2'b00, 8'h00, 2'b00, 4'h0, 1'b0,
                     C0, C0, C0, 0));

    reset_model();
    repeat (2) @(negedge i_clk);
    i_ce = 1'b1;
    check_out("reset");
    i_rst_n = 1'b1;

    repeat (4)
      apply(1'b1, 2'b00, 8'h00, 2'b00, 4'h0, 1'b0,
            1'b1, C0, C0, C0, 0, "ctrl00 idle");

    foreach (tab[i]) begin
      v = tab[i];
      apply(1'b1, v.m, v.d, v.c, v.a, v.g, 1'b1,
            v.x0, v.x1, v.x2, v.xb,
            $sformatf("vec%0d", i));
    end

    repeat (300) begin
      ce = ($urandom_range(0, 3) != 0);
      m = ($urandom_range(0, 9) == 0) ? 2'b00 : 2'b01;
      apply(ce, m, 8'($urandom), 2'($urandom), 4'h0,
            1'b0, 1'b0, C0, C0, C0, 0, "rand");
    end

    apply(1'b1, 2'b01, 8'h00, 2'b00, 4'h0, 1'b0,
          1'b0, C0, C0, C0, 0, "pre-rst");
    apply(1'b1, 2'b01, 8'h00, 2'b00, 4'h0, 1'b0,
          1'b0, C0, C0, C0, 0, "pre-rst");
    #2;
    i_rst_n = 1'b0;
    #1;
    reset_model();
    check_out("async rst");
    repeat (2) begin
      @(posedge i_clk);
      #1;
      check_out("rst hold");
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int i = 0; i < 6; i++)
      apply(1'b1, 2'b01, 8'(8'h5A + 8'(i * 37)), 2'b00,
            4'h0, 1'b0, 1'b0, C0, C0, C0, 0, "post-rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
